alu: RTL and testbench



---
 rtl/alu.sv | 154 +++++++++++++++
 tb/tb_alu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- integer ALU for the single-cycle RV32I core.
//
// Computes ADD/SUB/shift/compare/logic/PASS_B results together with the
// Z/N/C/V status flags. The default build is purely combinational. REG_OUT=1
// inserts one output register stage for timing-closure builds.
//
// Ports:
//   clk            in   core clock (only used when REG_OUT=1)
//   rst_n          in   asynchronous active-low reset (only used when REG_OUT=1)
//   source_a       in   operand A, XLEN bits
//   source_b       in   operand B, XLEN bits; low bits are the shift amount
//   alu_control    in   operation select (alu_op_e)
//   alu_result     out  operation result, XLEN bits
//   zero_flag      out  alu_result == 0
//   negative_flag  out  alu_result[XLEN-1]
//   carry_flag     out  unsigned carry-out, ADD/SUB only
//   overflow_flag  out  signed overflow, ADD/SUB only
// -----------------------------------------------------------------------------
module alu #(
   parameter int XLEN    = 32,
   parameter bit REG_OUT = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] source_a,
   input  logic [XLEN-1:0] source_b,
   input  logic [3:0]      alu_control,
   output logic [XLEN-1:0] alu_result,
   output logic            zero_flag,
   output logic            negative_flag,
   output logic            carry_flag,
   output logic            overflow_flag
);

   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_SLL    = 4'd2,
      OP_SLT    = 4'd3,
      OP_SLTU   = 4'd4,
      OP_XOR    = 4'd5,
      OP_SRL    = 4'd6,
      OP_SRA    = 4'd7,
      OP_OR     = 4'd8,
      OP_AND    = 4'd9,
      OP_PASS_B = 4'd10
   } alu_op_e;

   localparam int SHW = $clog2(XLEN);
   localparam int MSB = XLEN - 1;

   logic [SHW-1:0]  shamt;
   logic [XLEN:0]   add_sum;
   logic [XLEN:0]   sub_sum;
   logic            lt_signed;
   logic            lt_unsigned;

   logic [XLEN-1:0] result_d;
   logic            zero_d;
   logic            negative_d;
   logic            carry_d;
   logic            overflow_d;

   assign shamt = source_b[SHW-1:0];

   // Both adders are XLEN+1 bits wide so the top bit is the carry-out.
   // Subtraction is a + ~b + 1, so its carry means "no borrow" (a >= b).
   assign add_sum = {1'b0, source_a} + {1'b0, source_b};
   assign sub_sum = {1'b0, source_a} + {1'b0, ~source_b} + {{XLEN{1'b0}}, 1'b1};

   assign lt_signed   = $signed(source_a) < $signed(source_b);
   assign lt_unsigned = source_a < source_b;

   always_comb begin
      result_d   = '0;
      carry_d    = 1'b0;
      overflow_d = 1'b0;
      case (alu_control)
         OP_ADD: begin
            result_d   = add_sum[XLEN-1:0];
            carry_d    = add_sum[XLEN];
            overflow_d = (source_a[MSB] == source_b[MSB]) &&
                         (add_sum[MSB] != source_a[MSB]);
         end
         OP_SUB: begin
            result_d   = sub_sum[XLEN-1:0];
            carry_d    = sub_sum[XLEN];
            overflow_d = (source_a[MSB] != source_b[MSB]) &&
                         (sub_sum[MSB] != source_a[MSB]);
         end
         OP_SLL:    result_d = source_a << shamt;
         OP_SLT:    result_d = {{(XLEN-1){1'b0}}, lt_signed};
         OP_SLTU:   result_d = {{(XLEN-1){1'b0}}, lt_unsigned};
         OP_XOR:    result_d = source_a ^ source_b;
         OP_SRL:    result_d = source_a >> shamt;
         OP_SRA:    result_d = $unsigned($signed(source_a) >>> shamt);
         OP_OR:     result_d = source_a | source_b;
         OP_AND:    result_d = source_a & source_b;
         OP_PASS_B: result_d = source_b;
         // Illegal codes fall through with result 0, so Z=1 below.
         default:   result_d = '0;
      endcase
   end

   // Z and N always follow the final result, for every operation.
   assign zero_d     = (result_d == '0);
   assign negative_d = result_d[MSB];

   generate
      if (REG_OUT) begin : g_reg
         logic [XLEN-1:0] result_q;
         logic            zero_q;
         logic            negative_q;
         logic            carry_q;
         logic            overflow_q;

         // Reset clears every output, zero_flag included, and drops any
         // value that was about to be captured.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               result_q   <= '0;
               zero_q     <= 1'b0;
               negative_q <= 1'b0;
               carry_q    <= 1'b0;
               overflow_q <= 1'b0;
            end else begin
               result_q   <= result_d;
               zero_q     <= zero_d;
               negative_q <= negative_d;
               carry_q    <= carry_d;
               overflow_q <= overflow_d;
            end
         end

         assign alu_result    = result_q;
         assign zero_flag     = zero_q;
         assign negative_flag = negative_q;
         assign carry_flag    = carry_q;
         assign overflow_flag = overflow_q;
      end else begin : g_comb
         // Clock and reset have no function in the combinational build.
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst_n;

         assign alu_result    = result_d;
         assign zero_flag     = zero_d;
         assign negative_flag = negative_d;
         assign carry_flag    = carry_d;
         assign overflow_flag = overflow_d;
      end
   endgenerate

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- scoreboard bench for alu.
//
// Two instances share the stimulus: a combinational build (REG_OUT=0) and a
// registered build (REG_OUT=1). Each directed vector pushes its hand-computed
// expectation into one queue per instance. A monitor on the falling edge pops
// and compares: the combinational entry in the issue cycle, the registered
// entry one cycle later. Reset behaviour of the registered build is checked
// with directed steps at the end.
// -----------------------------------------------------------------------------
module tb_alu;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic [XLEN-1:0] source_a;
   logic [XLEN-1:0] source_b;
   logic [3:0]      alu_control;

   logic [XLEN-1:0] c_result, r_result;
   logic            c_z, c_n, c_c, c_v;
   logic            r_z, r_n, r_c, r_v;

   alu #(.XLEN(XLEN), .REG_OUT(1'b0)) u_comb (
      .clk           (clk),
      .rst_n         (rst_n),
      .source_a      (source_a),
      .source_b      (source_b),
      .alu_control   (alu_control),
      .alu_result    (c_result),
      .zero_flag     (c_z),
      .negative_flag (c_n),
      .carry_flag    (c_c),
      .overflow_flag (c_v)
   );

   alu #(.XLEN(XLEN), .REG_OUT(1'b1)) u_reg (
      .clk           (clk),
      .rst_n         (rst_n),
      .source_a      (source_a),
      .source_b      (source_b),
      .alu_control   (alu_control),
      .alu_result    (r_result),
      .zero_flag     (r_z),
      .negative_flag (r_n),
      .carry_flag    (r_c),
      .overflow_flag (r_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      int          cyc;
      string       name;
      logic [31:0] r;
      logic        z, n, c, v;
   } exp_t;

   exp_t q_comb[$];
   exp_t q_reg[$];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [31:0] r, input logic z,
                          input logic n, input logic c, input logic v,
                          input exp_t e);
      chk({nm, ".R"}, r, e.r);
      chk({nm, ".Z"}, {31'd0, z}, {31'd0, e.z});
      chk({nm, ".N"}, {31'd0, n}, {31'd0, e.n});
      chk({nm, ".C"}, {31'd0, c}, {31'd0, e.c});
      chk({nm, ".V"}, {31'd0, v}, {31'd0, e.v});
      $display("txn %-14s R=%h Z=%0b N=%0b C=%0b V=%0b", nm, r, z, n, c, v);
   endtask

   // Monitor: combinational result is due in the issue cycle, registered
   // result after the following rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (q_comb.size() > 0 && q_comb[0].cyc == cycle) begin
         e = q_comb.pop_front();
         chk_all({"comb.", e.name}, c_result, c_z, c_n, c_c, c_v, e);
      end
      if (q_reg.size() > 0 && q_reg[0].cyc == cycle - 1) begin
         e = q_reg.pop_front();
         chk_all({"reg.", e.name}, r_result, r_z, r_n, r_c, r_v, e);
      end
   end

   task automatic issue(input string nm, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic z, input logic n,
                        input logic c, input logic v);
      exp_t e;
      @(posedge clk);
      #1;
      alu_control = op;
      source_a    = a;
      source_b    = b;
      e.cyc  = cycle;
      e.name = nm;
      e.r    = r;
      e.z    = z;
      e.n    = n;
      e.c    = c;
      e.v    = v;
      q_comb.push_back(e);
      q_reg.push_back(e);
   endtask

   initial begin
      rst_n       = 1'b0;
      alu_control = 4'd0;
      source_a    = 32'h0000_0001;
      source_b    = 32'h0000_0002;

      // Registered build held in reset: everything 0, including Z.
      #2;
      chk("rst.R", r_result, 32'h0);
      chk("rst.Z", {31'd0, r_z}, 32'd0);
      chk("rst.NCV", {29'd0, r_n, r_c, r_v}, 32'd0);

      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;

      //          name         op     a             b             R             Z     N     C     V
      issue("add_ovf",    4'd0,  32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
      issue("add_wrap",   4'd0,  32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
      issue("add_negneg", 4'd0,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
      issue("sub_eq",     4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
      issue("sub_ovf",    4'd1,  32'h80000000, 32'h00000001, 32'h7fffffff, 1'b0, 1'b0, 1'b1, 1'b1);
      issue("sub_borrow", 4'd1,  32'h00000000, 32'h00000001, 32'hffffffff, 1'b0, 1'b1, 1'b0, 1'b0);
      issue("sub_1m2",    4'd1,  32'h00000001, 32'h00000002, 32'hffffffff, 1'b0, 1'b1, 1'b0, 1'b0);
      issue("sra",        4'd7,  32'h80000000, 32'h00000024, 32'hf8000000, 1'b0, 1'b1, 1'b0, 1'b0);
      issue("sra_pos",    4'd7,  32'h40000000, 32'h0000001e, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
      issue("srl",        4'd6,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0);
      issue("sll31",      4'd2,  32'h00000001, 32'h0000001f, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
      issue("sll_hib",    4'd2,  32'h00000003, 32'hffffffe1, 32'h00000006, 1'b0, 1'b0, 1'b0, 1'b0);
      issue("slt",        4'd3,  32'hffffffff, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
      issue("slt_f",      4'd3,  32'h00000001, 32'hffffffff, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
      issue("sltu",       4'd4,  32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
      issue("sltu_t",     4'd4,  32'h00000001, 32'hffffffff, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
      issue("and",        4'd9,  32'hf0f0f0f0, 32'h0f0f0f0f, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
      issue("or",         4'd8,  32'hf0f0f0f0, 32'h0f0f0f0f, 32'hffffffff, 1'b0, 1'b1, 1'b0, 1'b0);
      issue("xor",        4'd5,  32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
      issue("xor_nz",     4'd5,  32'h0000ff00, 32'h00000ff0, 32'h0000f0f0, 1'b0, 1'b0, 1'b0, 1'b0);
      issue("pass_b",     4'd10, 32'h12345678, 32'habcd0000, 32'habcd0000, 1'b0, 1'b1, 1'b0, 1'b0);
      issue("illegal15",  4'd15, 32'hffffffff, 32'hffffffff, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
      issue("illegal11",  4'd11, 32'h00000001, 32'h00000002, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
      issue("add_small",  4'd0,  32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0);

      // Registered-build latency: ADD 1+2 is not visible until the next edge.
      @(posedge clk);
      #1;
      alu_control = 4'd0;
      source_a    = 32'h1;
      source_b    = 32'h2;
      #1;
      chk("lat.before_edge", r_result, 32'h00000030);
      @(posedge clk);
      #1;
      chk("lat.after_edge", r_result, 32'h00000003);
      $display("txn lat_add      R=%h", r_result);

      // New operands pending, then reset between edges: immediate clear.
      source_a = 32'h5;
      source_b = 32'h6;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid.R", r_result, 32'h0);
      chk("rst_mid.flags", {28'd0, r_z, r_n, r_c, r_v}, 32'd0);
      $display("txn rst_mid      R=%h Z=%0b", r_result, r_z);

      // Held through an edge: stays cleared.
      @(posedge clk);
      #1;
      chk("rst_hold.R", r_result, 32'h0);
      chk("rst_hold.Z", {31'd0, r_z}, 32'd0);

      // Release between edges: nothing changes until the next rising edge.
      #2 rst_n = 1'b1;
      #1;
      chk("rel.R", r_result, 32'h0);
      @(posedge clk);
      #1;
      chk("rel.after_edge", r_result, 32'h0000000b);
      $display("txn rel_add      R=%h", r_result);

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 10 && (q_comb.size() + q_reg.size()) != 0; i++)
         @(posedge clk);
      checks++;
      if (q_comb.size() + q_reg.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d exp=0", q_comb.size() + q_reg.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout cycle=%0d exp=finish", cycle);
      $fatal(1, "timeout");
   end

endmodule
